regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 92 +++++++++
 tb/tb_regfile_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with x0, write bypass and pending-write issue scoreboard.
// Optional REGFILE_FLUSH_EN adds a flush input that drops all pending writes.
module regfile_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEBUG_REG     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    input  logic                     WE3,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     issue_valid,
    input  logic                     issue_use1,
    input  logic                     issue_use2,
    input  logic                     issue_we,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
`ifdef REGFILE_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     stall,
    output logic [ADDRESS_WIDTH:0]   pending,
    output logic [DATA_WIDTH-1:0]    a0
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] DBG = ADDRESS_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]       r_busy;
    logic [ADDRESS_WIDTH:0] r_pending;
    logic [DEPTH-1:0]       w_busy_eff;
    logic [DEPTH-1:0]       w_busy_next;
    logic [ADDRESS_WIDTH:0] w_count;
    logic                   w_clr;
    logic                   w_raw;
    logic                   w_waw;
    logic                   w_fire;
    logic                   w_flush;

`ifdef REGFILE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_clr = WE3 && rd != '0;

    // A writeback landing this cycle resolves the hazard on its register.
    always_comb begin
        w_busy_eff = r_busy;
        if (w_clr) w_busy_eff[rd] = 1'b0;
    end

    assign w_raw  = issue_valid && ((issue_use1 && rs1 != '0 && w_busy_eff[rs1]) ||
                                    (issue_use2 && rs2 != '0 && w_busy_eff[rs2]));
    assign w_waw  = issue_valid && issue_we && issue_rd != '0 && w_busy_eff[issue_rd];
    assign stall  = !w_flush && (w_raw || w_waw);
    assign w_fire = issue_valid && !stall && issue_we && issue_rd != '0 && !w_flush;

    always_comb begin
        w_busy_next = w_busy_eff;
        if (w_fire) w_busy_next[issue_rd] = 1'b1;
        if (w_flush) w_busy_next = '0;
        w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) w_count = w_count + (ADDRESS_WIDTH+1)'(w_busy_next[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            if (w_clr) r_regs[rd] <= WD3;
            r_busy    <= w_busy_next;
            r_pending <= w_count;
        end
    end

    assign RD1     = rs1 == '0 ? '0 : (w_clr && rd == rs1) ? WD3 : r_regs[rs1];
    assign RD2     = rs2 == '0 ? '0 : (w_clr && rd == rs2) ? WD3 : r_regs[rs2];
    assign a0      = r_regs[DBG];
    assign pending = r_pending;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: queue-based self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, issue_rd;
    logic [31:0] RD1, RD2, WD3, a0;
    logic        WE3, issue_valid, issue_use1, issue_use2, issue_we, stall;
    logic [5:0]  pending;
`ifdef REGFILE_FLUSH_EN
    logic        flush;
`endif
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          checks = 0;
    int          failures = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .rd(rd), .WD3(WD3), .issue_valid(issue_valid),
        .issue_use1(issue_use1), .issue_use2(issue_use2), .issue_we(issue_we),
        .issue_rd(issue_rd),
`ifdef REGFILE_FLUSH_EN
        .flush(flush),
`endif
        .stall(stall), .pending(pending), .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; WD3 = '0; WE3 = 1'b0;
        issue_valid = 1'b0; issue_use1 = 1'b0; issue_use2 = 1'b0;
        issue_we = 1'b0; issue_rd = '0;
`ifdef REGFILE_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_rd(input logic [4:0] r);
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = r;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rs1 = 5'd5;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL reset_pending got=%0d exp=%0d", pending, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL reset_stall got=%0d exp=%0d", stall, e); end
        @(negedge clk) rst = 1'b0;
        cyc();
        WE3 = 1'b1; rd = 5'd5; WD3 = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
        cyc();
        idle();
        rs1 = 5'd5;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL prereset_rd1 got=%h exp=%h", RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL prereset_pending got=%0d exp=%0d", pending, e); end
        rst = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL async_reset_rd1 got=%h exp=%h", RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL async_reset_pending got=%0d exp=%0d", pending, e); end
        @(negedge clk) rst = 1'b0;
        cyc();
    endtask

    task automatic test_x0();
        idle();
        WE3 = 1'b1; rd = 5'd0; WD3 = 32'h1234;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL x0_bypass got=%h exp=%h", RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL x0_stall got=%0d exp=%0d", stall, e); end
        cyc();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL x0_after got=%h exp=%h", RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL x0_pending got=%0d exp=%0d", pending, e); end
    endtask

    task automatic test_bypass();
        idle();
        WE3 = 1'b1; rd = 5'd7; WD3 = 32'hA5A5A5A5; rs2 = 5'd7;
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD2 !== e) begin failures++; $display("FAIL bypass_same got=%h exp=%h", RD2, e); end
        cyc();
        idle();
        rs2 = 5'd7;
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        e = exp_q.pop_front(); checks++;
        if (RD2 !== e) begin failures++; $display("FAIL bypass_stored got=%h exp=%h", RD2, e); end
    endtask

    task automatic test_raw();
        fire_rd(5'd3);
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL raw_pending1 got=%0d exp=%0d", pending, e); end
        issue_valid = 1'b1; issue_use1 = 1'b1; rs1 = 5'd3; issue_we = 1'b1; issue_rd = 5'd9;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL raw_stall got=%0d exp=%0d", stall, e); end
        cyc();
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL raw_stall_noeffect got=%0d exp=%0d", pending, e); end
        issue_we = 1'b0; issue_rd = 5'd0;
        WE3 = 1'b1; rd = 5'd3; WD3 = 32'h33;
        exp_q.push_back(32'd0); exp_q.push_back(32'h33);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL raw_resolved_stall got=%0d exp=%0d", stall, e); end
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL raw_resolved_rd1 got=%h exp=%h", RD1, e); end
        cyc();
        idle();
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL raw_pending0 got=%0d exp=%0d", pending, e); end
    endtask

    task automatic test_same_cycle();
        fire_rd(5'd4);
        WE3 = 1'b1; rd = 5'd4; WD3 = 32'h44;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL setclr_stall got=%0d exp=%0d", stall, e); end
        cyc();
        idle();
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL setclr_pending got=%0d exp=%0d", pending, e); end
        WE3 = 1'b1; rd = 5'd4; WD3 = 32'h45;
        cyc();
        idle();
    endtask

    task automatic test_waw_debug();
        fire_rd(5'd10);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL waw_stall got=%0d exp=%0d", stall, e); end
        idle();
        WE3 = 1'b1; rd = 5'd10; WD3 = 32'd42;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin failures++; $display("FAIL a0_nobypass got=%0d exp=%0d", a0, e); end
        cyc();
        idle();
        exp_q.push_back(32'd42); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin failures++; $display("FAIL a0_written got=%0d exp=%0d", a0, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL waw_pending got=%0d exp=%0d", pending, e); end
    endtask

    task automatic test_fill();
        for (int r = 1; r < 32; r++) fire_rd(5'(r));
        exp_q.push_back(32'd31);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL fill_pending got=%0d exp=%0d", pending, e); end
        issue_valid = 1'b1; issue_use2 = 1'b1; rs2 = 5'd31;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL fill_rs2_stall got=%0d exp=%0d", stall, e); end
        idle();
        rst = 1'b1;
        #2;
        @(negedge clk) rst = 1'b0;
        cyc();
    endtask

`ifdef REGFILE_FLUSH_EN
    task automatic test_flush();
        fire_rd(5'd1); fire_rd(5'd2); fire_rd(5'd6);
        exp_q.push_back(32'd3);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL flush_pre got=%0d exp=%0d", pending, e); end
        flush = 1'b1; issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd1;
        WE3 = 1'b1; rd = 5'd2; WD3 = 32'd77;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(stall) !== e) begin failures++; $display("FAIL flush_stall got=%0d exp=%0d", stall, e); end
        cyc();
        idle();
        rs1 = 5'd2;
        exp_q.push_back(32'd0); exp_q.push_back(32'd77);
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pending) !== e) begin failures++; $display("FAIL flush_pending got=%0d exp=%0d", pending, e); end
        e = exp_q.pop_front(); checks++;
        if (RD1 !== e) begin failures++; $display("FAIL flush_write got=%0d exp=%0d", RD1, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_x0();
        test_bypass();
        test_raw();
        test_same_cycle();
        test_waw_debug();
        test_fill();
`ifdef REGFILE_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
